// File: rtl/prog_clk_divider.sv
// ---------------------------------------------------------------------------
// prog_clk_divider
//
// Runtime-programmable clock-enable divider. A period of div_r cycles is
// counted in cnt; divided_clk is high for the first high_r cycles of every
// period and tick marks the first cycle of every period. Software requests a
// new divisor/high-time pair over a valid/ready port; an accepted request is
// parked in pend_* and only swapped in on a period boundary, so the output
// never shows a truncated or stretched period.
//
// The output is a registered level in the clk domain, intended as a timing
// reference or enable for peripherals, not as a clock for a new clock tree.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          asynchronous active-low reset (release synchronous to clk)
//   en           count enable; when low all counting state holds
//   cfg_valid    configuration request strobe
//   cfg_div      requested divisor (period length in clk cycles)
//   cfg_high     requested high cycles per period
//   cfg_ready    high when no configuration is pending
//   cfg_err      one-cycle pulse after a rejected configuration request
//   divided_clk  registered divided output level
//   tick         one-cycle pulse on the first cycle of each period
//
// Parameters:
//   WIDTH         counter / divisor / high-time width (>= 2)
//   DEFAULT_DIV   divisor after reset, 1 .. 2^WIDTH-1
//   DEFAULT_HIGH  high cycles after reset, <= DEFAULT_DIV
// ---------------------------------------------------------------------------
module prog_clk_divider #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 2,
  parameter int DEFAULT_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             divided_clk,
  output logic             tick
);

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_HIGH);
  // Reset parks the counter on the last count so the very first enabled
  // edge wraps and starts a full period instead of a short one.
  localparam logic [WIDTH-1:0] RST_CNT  = WIDTH'(DEFAULT_DIV - 1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] high_r;
  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] pend_high;
  logic             pend_v;

  logic             wrap;
  logic             apply_cfg;
  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] high_eff;
  logic             cfg_ok;
  logic             cfg_accept;

  // cnt never exceeds div_r-1, so the equality compare is the only wrap
  // condition needed. With div_r == 1 this is always true, which gives the
  // tick-every-cycle behaviour without special casing.
  assign wrap      = (cnt == div_r - WIDTH'(1));
  assign apply_cfg = en && wrap && pend_v;
  assign cnt_n     = wrap ? '0 : cnt + WIDTH'(1);

  // The output level of the first cycle of a new period must already use
  // the incoming high time, otherwise the first period after an update
  // would carry the old duty.
  assign high_eff  = apply_cfg ? pend_high : high_r;

  // A zero divisor has no meaning and a high time longer than the period
  // cannot be represented; both are refused rather than clamped.
  assign cfg_ok     = (cfg_div != '0) && (cfg_high <= cfg_div);
  assign cfg_accept = cfg_valid && !pend_v;

  assign cfg_ready  = !pend_v;

  // Single state register block. The config handshake runs regardless of
  // en; counting and output updates only advance on enabled edges. An
  // accepted request cannot be applied on its own accept edge because
  // apply_cfg needs pend_v to already be set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= RST_CNT;
      div_r       <= RST_DIV;
      high_r      <= RST_HIGH;
      pend_div    <= '0;
      pend_high   <= '0;
      pend_v      <= 1'b0;
      divided_clk <= 1'b0;
      tick        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= 1'b0;

      if (en) begin
        if (apply_cfg) begin
          div_r  <= pend_div;
          high_r <= pend_high;
          pend_v <= 1'b0;
        end
        cnt         <= cnt_n;
        divided_clk <= (cnt_n < high_eff);
        tick        <= (cnt_n == '0);
      end else begin
        tick <= 1'b0;
      end

      if (cfg_accept) begin
        if (cfg_ok) begin
          pend_div  <= cfg_div;
          pend_high <= cfg_high;
          pend_v    <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
- Runtime-programmable clock-enable divider: the successor to the fixed divide-by-DIV 50%-duty divider.
- Adds a per-period programmable divisor and high time (duty), a count enable, a period-start tick, and a valid/ready config port with glitch-free updates applied only at period boundaries.
- Used wherever peripherals (UART/SPI/PWM timing) need a rate that software can change at run time; the output is a registered level in the clk domain, not a new clock tree.

Parameters:
- WIDTH, 8: width of counter, divisor and high-time fields; must be >= 2.
- DEFAULT_DIV, 2: divisor after reset; must satisfy 1 <= DEFAULT_DIV <= 2^WIDTH-1.
- DEFAULT_HIGH, 1: high cycles per period after reset; must be <= DEFAULT_DIV.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-low reset: assertion (rst=0) resets immediately, release is synchronous to clk.
- en  in  1  count enable; when low all state holds.
- cfg_valid  in  1  config request.
- cfg_div  in  WIDTH  requested divisor, period = cfg_div cycles.
- cfg_high  in  WIDTH  requested high cycles per period.
- cfg_ready  out  1  high when no config is pending.
- cfg_err  out  1  one-cycle pulse when a config was rejected.
- divided_clk  out  1  registered divided output.
- tick  out  1  one-cycle pulse on the first cycle of each period.

Behaviour:
- State: cnt[WIDTH], div_r, high_r (active), pend_div, pend_high, pend_v.
- Reset values:
  - cnt = DEFAULT_DIV-1, div_r = DEFAULT_DIV, high_r = DEFAULT_HIGH, pend_v = 0.
  - divided_clk = 0, tick = 0, cfg_err = 0, cfg_ready = 1.
- Enabled edge (en=1):
  - wrap = (cnt == div_r-1).
  - If wrap and pend_v: div_r <= pend_div, high_r <= pend_high, pend_v <= 0.
  - cnt_n = wrap ? 0 : cnt+1; cnt <= cnt_n.
  - divided_clk <= (cnt_n < high_eff), where high_eff is the new high_r if updating on this edge, otherwise the old high_r.
  - tick <= (cnt_n == 0).
- Startup: the first enabled edge after reset wraps, so tick=1 and divided_clk=(0<DEFAULT_HIGH). No short first period.
- en=0 edge: cnt, divided_clk, div_r and high_r hold; tick <= 0. Pending update waits. Phase resumes exactly where it stopped.
- Config accept: on cfg_valid && cfg_ready.
  - Valid request (cfg_div != 0 and cfg_high <= cfg_div): pend_* <= cfg_*, pend_v <= 1, so cfg_ready = 0 from the next cycle.
  - Invalid request: nothing stored, cfg_ready stays 1, cfg_err = 1 on the next cycle only.
  - cfg_valid while cfg_ready=0 is ignored: no error, no store.
- An accepted config is never applied on its own accept edge. It applies at the first subsequent enabled wrap edge; cfg_ready returns to 1 after that edge.
- Degenerate settings are legal and have defined behaviour:
  - div=1: cnt stuck at 0, tick every enabled cycle.
  - high=0: divided_clk constant 0.
  - high=div: divided_clk constant 1.
- cfg_err and the config handshake are independent of en.
- Reset asserted mid-operation: all state returns to reset values asynchronously; any pending config is discarded.
- Max divisor 2^WIDTH-1; cnt never exceeds div_r-1, with no overflow path.

Test Plan:
- Reset release, en=1, defaults (2/1): divided_clk 1,0,1,0… from the first edge; tick 1,0,1,0…; cfg_ready=1.
- cfg div=5 high=2 accepted mid-period: current 2-cycle period completes. Then divided_clk repeats 1,1,0,0,0, tick once per 5 cycles, cfg_ready low from accept until the applying edge.
- cfg div=0, then div=3 high=4: cfg_err pulses once for each; settings unchanged; cfg_ready stays 1.
- With div=5 high=2, drop en for 3 cycles at cnt=1: outputs frozen, tick=0; after re-enable, the period completes with 3 further cycles and no phase loss.
- div=1 high=1 then div=1 high=0: divided_clk constant 1 and then constant 0; tick=1 every cycle in both.
- Pending config (div=7) with en=0, then pulse rst low: outputs 0 immediately, pend_v cleared, div_r=2. After release, 2/1 pattern resumes.
